goal_detector: RTL and testbench
================================

Name: goal_detector

Overview:
- Upstream stage of the match controller. Watches the ball position once per frame.
- Raises single-cycle patrick_goal / zuofu_goal pulses when the ball sits fully inside a goal mouth for a confirmed number of frames.
- Locks out further goals until the ball has left the goal.
- Also raises gameover when either score reaches the winning total.

Parameters:
- GOAL_Y_MIN, 180, top edge of both goal mouths (pixel row).
- GOAL_Y_MAX, 300, bottom edge of both goal mouths.
- LEFT_X, 20, right edge of the left goal; the ball is inside when its right edge is <= LEFT_X.
- RIGHT_X, 619, left edge of the right goal; the ball is inside when its left edge is >= RIGHT_X.
- CONFIRM_FRAMES, 2, consecutive in-goal frame ticks required before a goal is counted (1..7).
- WIN_SCORE, 5, score at which gameover asserts (1..7).

Ports:
- CLK  in  1  system clock
- Reset  in  1  synchronous, active-high reset
- frame_clk  in  1  frame strobe, synchronous to CLK; its rising edge marks a new frame
- game_start  in  1  high while the match is in play
- ball_x  in  10  ball centre X
- ball_y  in  10  ball centre Y
- ball_size  in  10  ball half-size
- patrick_score  in  3  current Patrick score
- zuofu_score  in  3  current Zuofu score
- patrick_goal  out  1  one-cycle pulse: ball confirmed in the right goal
- zuofu_goal  out  1  one-cycle pulse: ball confirmed in the left goal
- gameover  out  1  registered level: a score has reached WIN_SCORE

Behaviour:
- Reset: state=DISARMED, count=0, side=0, patrick_goal=0, zuofu_goal=0, gameover=0, frame_clk history register=0.
- Frame tick: frame_clk is registered once. tick = frame_clk & ~frame_clk_q, high for one CLK. Region evaluation and counting happen only on tick cycles.
- Region math uses 11-bit unsigned arithmetic, with no subtraction of ball_size, so nothing underflows:
  - in_y = (ball_y >= GOAL_Y_MIN + ball_size) && (ball_y + ball_size <= GOAL_Y_MAX)
  - in_left = in_y && (ball_x + ball_size <= LEFT_X)
  - in_right = in_y && (ball_x >= RIGHT_X + ball_size)
  - LEFT_X < RIGHT_X guarantees in_left and in_right are never both true.
- gameover is registered each cycle as (patrick_score >= WIN_SCORE) || (zuofu_score >= WIN_SCORE). It is not gated by game_start and clears one cycle after the scores drop below WIN_SCORE.
- Global override, checked first every cycle: if game_start=0 or gameover=1, then state becomes DISARMED and count becomes 0. No pulse is issued in that cycle.
- FSM states: DISARMED, ARMED, CONFIRM, SCORED.
  - DISARMED -> ARMED on the cycle game_start=1 and gameover=0.
  - ARMED, on tick with in_left or in_right: latch side (left=zuofu, right=patrick) and set count=1.
    - If CONFIRM_FRAMES=1: issue the pulse and go to SCORED.
    - Otherwise: go to CONFIRM.
  - CONFIRM, on tick:
    - Ball still in the latched side: count+1. When count+1 == CONFIRM_FRAMES, issue the pulse and go to SCORED.
    - Ball outside the latched side, including in the opposite goal: count=0 and go to ARMED. The opposite goal is re-evaluated on the next tick, not the same one.
  - SCORED, on tick with neither in_left nor in_right: go to ARMED and set count=0. Ball still in a goal: stay in SCORED; no further pulses.
- Pulse timing:
  - patrick_goal / zuofu_goal are registered and high for exactly the one CLK after the confirming tick.
  - Never both high. Never high in consecutive cycles.
  - Between pulses, the FSM must pass through an out-of-goal tick.
- Non-tick cycles: state, count and side hold, except for the global override.
- Reset mid-CONFIRM or mid-SCORED returns to DISARMED. No pulse is emitted in the reset cycle or the cycle after it.

Test Plan:
1. Reset=1 for 2 cycles, then game_start=1 with the ball at centre (320,240,size 4) for 10 ticks -> all outputs stay 0; FSM reaches ARMED one cycle after Reset drops.
2. Ball at (630,240,4), CONFIRM_FRAMES=2, held for 5 ticks -> exactly one patrick_goal pulse, one CLK after the 2nd tick; zuofu_goal stays 0. Move the ball to (320,240) for 1 tick, then back to (630,240) for 2 ticks -> a second patrick_goal pulse.
3. Ball at (10,240,4) for 1 tick, then (320,240) for 1 tick, then (10,240) for 1 tick -> no pulse. A 2nd consecutive tick at (10,240) -> zuofu_goal pulse.
4. Edge geometry:
   - (16,240,4): right edge 20 equals LEFT_X -> counts as in goal.
   - (17,240,4) -> not in goal.
   - (10,178,4): top edge 174 is above GOAL_Y_MIN -> no goal.
   - ball_y=2, size 4 -> no false in_y from underflow.
5. Score inputs patrick=4 then 5 -> gameover rises one cycle after 5 is applied. With the ball held in the right goal, no pulses are emitted. Scores back to 0 -> gameover clears the next cycle.
6. game_start dropped mid-CONFIRM (after 1 of 2 ticks) then restored, ball held in goal -> counting restarts. Pulse arrives one CLK after the 2nd tick following restore.

Source files
------------

// File: rtl/goal_detector_if.sv
// rtl/goal_detector_if.sv - ball/score inputs and goal/gameover outputs of the goal detector
//
// Purpose: bundles the per-frame game signals seen by goal_detector.
// Ports (all carried inside the interface):
//   frame_clk      frame strobe, rising edge marks a new frame
//   game_start     high while the match is in play
//   ball_x/ball_y  ball centre, pixels
//   ball_size      ball half-size, pixels
//   patrick_score  current Patrick score
//   zuofu_score    current Zuofu score
//   patrick_goal   one-cycle pulse, ball confirmed in the right goal
//   zuofu_goal     one-cycle pulse, ball confirmed in the left goal
//   gameover       level, a score has reached the winning total
// Modports: master drives the game state, slave is the detector.
interface goal_detector_if;
  logic       frame_clk;
  logic       game_start;
  logic [9:0] ball_x;
  logic [9:0] ball_y;
  logic [9:0] ball_size;
  logic [2:0] patrick_score;
  logic [2:0] zuofu_score;
  logic       patrick_goal;
  logic       zuofu_goal;
  logic       gameover;

  modport master (
    output frame_clk, game_start, ball_x, ball_y, ball_size,
           patrick_score, zuofu_score,
    input  patrick_goal, zuofu_goal, gameover
  );

  modport slave (
    input  frame_clk, game_start, ball_x, ball_y, ball_size,
           patrick_score, zuofu_score,
    output patrick_goal, zuofu_goal, gameover
  );
endinterface

// File: rtl/goal_detector.sv
// rtl/goal_detector.sv - per-frame goal detection with confirmation and lockout
//
// Purpose: watches the ball once per frame, emits a single-cycle goal pulse
// once the ball has sat fully inside a goal mouth for CONFIRM_FRAMES
// consecutive frames, then locks out until the ball leaves the goal.
// Ports:
//   CLK    system clock
//   Reset  synchronous, active-high reset
//   bus    goal_detector_if.slave (frame strobe, ball, scores in; goals, gameover out)
module goal_detector #(
  parameter int unsigned GOAL_Y_MIN     = 180,
  parameter int unsigned GOAL_Y_MAX     = 300,
  parameter int unsigned LEFT_X         = 20,
  parameter int unsigned RIGHT_X        = 619,
  parameter int unsigned CONFIRM_FRAMES = 2,
  parameter int unsigned WIN_SCORE      = 5
) (
  input logic           CLK,
  input logic           Reset,
  goal_detector_if.slave bus
);

  typedef enum logic [1:0] {DISARMED, ARMED, CONFIRM, SCORED} state_t;

  localparam logic [10:0] Y_MIN  = 11'(GOAL_Y_MIN);
  localparam logic [10:0] Y_MAX  = 11'(GOAL_Y_MAX);
  localparam logic [10:0] L_X    = 11'(LEFT_X);
  localparam logic [10:0] R_X    = 11'(RIGHT_X);
  localparam logic [3:0]  CF     = 4'(CONFIRM_FRAMES);
  localparam logic [2:0]  WIN    = 3'(WIN_SCORE);

  state_t     state, state_d;
  logic [2:0] count, count_d;
  logic       side, side_d;          // 1 = right goal (patrick), 0 = left goal (zuofu)
  logic       frame_clk_q;
  logic       tick;
  logic       patrick_goal_q, zuofu_goal_q, gameover_q;
  logic       patrick_goal_d, zuofu_goal_d;
  logic       override;

  // Widened to 11 bits so ball +/- size never wraps; size is only ever added.
  logic [10:0] bx, by, bs;
  logic        in_y, in_left, in_right, in_side;
  logic [3:0]  count_inc;

  assign bx = {1'b0, bus.ball_x};
  assign by = {1'b0, bus.ball_y};
  assign bs = {1'b0, bus.ball_size};

  assign in_y     = (by >= Y_MIN + bs) && (by + bs <= Y_MAX);
  assign in_left  = in_y && (bx + bs <= L_X);
  assign in_right = in_y && (bx >= R_X + bs);
  assign in_side  = side ? in_right : in_left;

  assign tick      = bus.frame_clk & ~frame_clk_q;
  assign count_inc = {1'b0, count} + 4'd1;
  assign override  = ~bus.game_start | gameover_q;

  // State register
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state          <= DISARMED;
      count          <= 3'd0;
      side           <= 1'b0;
      frame_clk_q    <= 1'b0;
      patrick_goal_q <= 1'b0;
      zuofu_goal_q   <= 1'b0;
      gameover_q     <= 1'b0;
    end else begin
      state          <= state_d;
      count          <= count_d;
      side           <= side_d;
      frame_clk_q    <= bus.frame_clk;
      patrick_goal_q <= patrick_goal_d;
      zuofu_goal_q   <= zuofu_goal_d;
      gameover_q     <= (bus.patrick_score >= WIN) || (bus.zuofu_score >= WIN);
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state;
    count_d = count;
    side_d  = side;
    if (override) begin
      state_d = DISARMED;
      count_d = 3'd0;
    end else begin
      case (state)
        DISARMED: state_d = ARMED;
        ARMED: begin
          if (tick && (in_left || in_right)) begin
            side_d  = in_right;
            count_d = 3'd1;
            state_d = (CONFIRM_FRAMES == 1) ? SCORED : CONFIRM;
          end
        end
        CONFIRM: begin
          if (tick) begin
            if (in_side) begin
              count_d = count_inc[2:0];
              if (count_inc == CF) state_d = SCORED;
            end else begin
              // Opposite goal is not taken here; it is re-evaluated from ARMED next tick.
              count_d = 3'd0;
              state_d = ARMED;
            end
          end
        end
        SCORED: begin
          if (tick && !in_left && !in_right) begin
            count_d = 3'd0;
            state_d = ARMED;
          end
        end
        default: begin
          state_d = DISARMED;
          count_d = 3'd0;
        end
      endcase
    end
  end

  // Output logic: pulse request for the cycle after the confirming tick
  always_comb begin
    patrick_goal_d = 1'b0;
    zuofu_goal_d   = 1'b0;
    if (!override && tick) begin
      if (state == ARMED && CONFIRM_FRAMES == 1 && (in_left || in_right)) begin
        patrick_goal_d = in_right;
        zuofu_goal_d   = in_left;
      end else if (state == CONFIRM && in_side && count_inc == CF) begin
        patrick_goal_d = side;
        zuofu_goal_d   = ~side;
      end
    end
  end

  assign bus.patrick_goal = patrick_goal_q;
  assign bus.zuofu_goal   = zuofu_goal_q;
  assign bus.gameover     = gameover_q;

endmodule

// File: tb/tb_goal_detector.sv
// tb/tb_goal_detector.sv - directed self-checking bench for goal_detector
module tb_goal_detector;

  logic CLK = 1'b0;
  logic Reset;
  int   total = 0;
  int   bad   = 0;
  int   pg_cnt = 0;
  int   zg_cnt = 0;
  int   viol   = 0;
  logic prev_any = 1'b0;
  logic pg, zg;

  goal_detector_if gif ();

  goal_detector dut (
    .CLK   (CLK),
    .Reset (Reset),
    .bus   (gif.slave)
  );

  always #5 CLK = ~CLK;

  // Pulse bookkeeping: counts pulses, flags both-high or back-to-back pulses.
  always @(negedge CLK) begin
    if (gif.patrick_goal) pg_cnt++;
    if (gif.zuofu_goal) zg_cnt++;
    if (gif.patrick_goal && gif.zuofu_goal) viol++;
    if ((gif.patrick_goal || gif.zuofu_goal) && prev_any) viol++;
    prev_any = gif.patrick_goal | gif.zuofu_goal;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic ball(input int x, input int y, input int s);
    gif.ball_x    = 10'(x);
    gif.ball_y    = 10'(y);
    gif.ball_size = 10'(s);
  endtask

  // One frame: strobe high for one cycle, sample the pulse one CLK after the tick.
  task automatic frame(output logic p, output logic z);
    gif.frame_clk = 1'b1;
    @(negedge CLK);
    p = gif.patrick_goal;
    z = gif.zuofu_goal;
    gif.frame_clk = 1'b0;
    step(2);
  endtask

  initial begin
    Reset             = 1'b1;
    gif.frame_clk     = 1'b0;
    gif.game_start    = 1'b0;
    gif.patrick_score = 3'd0;
    gif.zuofu_score   = 3'd0;
    ball(320, 240, 4);
    step(2);
    chk("rst_pg", 32'(gif.patrick_goal), 0);
    chk("rst_zg", 32'(gif.zuofu_goal), 0);
    chk("rst_go", 32'(gif.gameover), 0);
    chk("rst_state", 32'(dut.state), 0);

    // 1: centre ball, no goals
    Reset = 1'b0;
    gif.game_start = 1'b1;
    step(1);
    chk("armed_after_reset", 32'(dut.state), 1);
    for (int i = 0; i < 10; i++) begin
      frame(pg, zg);
      chk("centre_no_pulse", 32'(pg | zg), 0);
    end
    chk("centre_go", 32'(gif.gameover), 0);

    // 2: right goal, confirmed on 2nd tick, lockout, re-score after exit
    ball(630, 240, 4);
    frame(pg, zg); chk("r_t1", 32'(pg), 0);
    frame(pg, zg); chk("r_t2_pulse", 32'(pg), 1); chk("r_t2_zg", 32'(zg), 0);
    for (int i = 0; i < 3; i++) begin
      frame(pg, zg); chk("r_lockout", 32'(pg | zg), 0);
    end
    chk("r_cnt1", pg_cnt, 1);
    ball(320, 240, 4); frame(pg, zg);
    ball(630, 240, 4);
    frame(pg, zg); chk("r2_t1", 32'(pg), 0);
    frame(pg, zg); chk("r2_t2_pulse", 32'(pg), 1);

    // 3: left goal interrupted, then confirmed
    ball(320, 240, 4); frame(pg, zg);
    ball(10, 240, 4);  frame(pg, zg); chk("l_a", 32'(zg), 0);
    ball(320, 240, 4); frame(pg, zg); chk("l_b", 32'(zg), 0);
    ball(10, 240, 4);  frame(pg, zg); chk("l_c", 32'(zg), 0);
    frame(pg, zg); chk("l_pulse", 32'(zg), 1); chk("l_pulse_pg", 32'(pg), 0);

    // 4: edge geometry
    ball(320, 240, 4); frame(pg, zg);
    ball(16, 240, 4);
    frame(pg, zg); chk("e16_t1", 32'(zg), 0);
    frame(pg, zg); chk("e16_pulse", 32'(zg), 1);
    ball(320, 240, 4); frame(pg, zg);
    ball(17, 240, 4);
    frame(pg, zg); frame(pg, zg); chk("e17_none", 32'(pg | zg), 0);
    chk("e17_state", 32'(dut.state), 1);
    ball(10, 178, 4);
    frame(pg, zg); frame(pg, zg); chk("e_top_none", 32'(pg | zg), 0);
    chk("e_top_state", 32'(dut.state), 1);
    ball(10, 2, 4);
    frame(pg, zg); frame(pg, zg); chk("e_uflow_none", 32'(pg | zg), 0);
    chk("e_uflow_state", 32'(dut.state), 1);
    ball(623, 240, 4);
    frame(pg, zg); chk("e623_t1", 32'(pg), 0);
    frame(pg, zg); chk("e623_pulse", 32'(pg), 1);
    ball(320, 240, 4); frame(pg, zg);

    // 5: gameover
    ball(630, 240, 4);
    gif.patrick_score = 3'd4;
    step(1); chk("go_at4", 32'(gif.gameover), 0);
    gif.patrick_score = 3'd5;
    step(1); chk("go_at5", 32'(gif.gameover), 1);
    for (int i = 0; i < 3; i++) begin
      frame(pg, zg); chk("go_no_pulse", 32'(pg | zg), 0);
    end
    chk("go_state", 32'(dut.state), 0);
    ball(320, 240, 4);
    gif.patrick_score = 3'd0;
    step(1); chk("go_clear", 32'(gif.gameover), 0);
    step(1); chk("go_rearm", 32'(dut.state), 1);

    // 6: game_start dropped mid-CONFIRM restarts counting
    ball(630, 240, 4);
    frame(pg, zg); chk("gs_t1", 32'(pg), 0);
    chk("gs_confirm", 32'(dut.state), 2);
    gif.game_start = 1'b0;
    step(1); chk("gs_disarmed", 32'(dut.state), 0);
    gif.game_start = 1'b1;
    step(1); chk("gs_armed", 32'(dut.state), 1);
    frame(pg, zg); chk("gs_restart_t1", 32'(pg), 0);
    frame(pg, zg); chk("gs_restart_pulse", 32'(pg), 1);

    // Reset mid-CONFIRM restarts counting
    ball(320, 240, 4); frame(pg, zg);
    ball(630, 240, 4); frame(pg, zg);
    chk("rc_confirm", 32'(dut.state), 2);
    Reset = 1'b1;
    step(1);
    chk("rc_state", 32'(dut.state), 0);
    chk("rc_pg", 32'(gif.patrick_goal), 0);
    Reset = 1'b0;
    step(1);
    chk("rc_after_pg", 32'(gif.patrick_goal), 0);
    frame(pg, zg); chk("rc_t1", 32'(pg), 0);
    frame(pg, zg); chk("rc_pulse", 32'(pg), 1);

    step(2);
    chk("pg_total", pg_cnt, 5);
    chk("zg_total", zg_cnt, 2);
    chk("pulse_rules", viol, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
